// File: rtl/uivbuf_pkg.sv
// ============================================================================
// Module   : uivbuf_pkg
// Purpose  : Shared types and widths for the video buffer read/write schedulers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uivbuf_pkg;

   localparam int BUF_IDX_W   = 4;
   localparam int FDMA_SIZE_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_DATA = 3'd1,
      ST_REQ       = 3'd2,
      ST_BUSY      = 3'd3,
      ST_DONE      = 3'd4
   } wr_state_e;

endpackage

`default_nettype wire

// File: rtl/uivbuf_wctrl.sv
// ============================================================================
// Module   : uivbuf_wctrl
// Purpose  : Write-side frame scheduler issuing fixed-length FDMA bursts into
//            rotating DDR frame buffers. Optional UIVBUF_SW_SEL_EN selects the
//            buffer from software instead of round-robin.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uivbuf_wctrl
   import uivbuf_pkg::*;
#(
   parameter int          ADDR_W           = 32,
   parameter int          DATA_BYTES       = 8,
   parameter int          BURST_LEN        = 256,
   parameter int          BURSTS_PER_FRAME = 2025,
   parameter int          BUF_NUM          = 3,
   parameter logic [31:0] BUF_BASE         = 32'h1000_0000,
   parameter logic [31:0] BUF_SIZE         = 32'h0080_0000,
   parameter int          CNT_W            = 12
) (
   input  logic                   S_AXI_ACLK,
   input  logic                   S_AXI_ARESETN,
   input  logic                   frame_start,
   input  logic [CNT_W-1:0]       fifo_rcnt,
   output logic [ADDR_W-1:0]      fdma_waddr,
   output logic                   fdma_wareq,
   output logic [FDMA_SIZE_W-1:0] fdma_wsize,
   input  logic                   fdma_wbusy,
   input  logic [BUF_IDX_W-1:0]   axi_fdma_wbuf,
   output logic                   fdma_wirq,
   output logic [BUF_IDX_W-1:0]   fdma_wbuf,
   output logic                   wr_active
);

   localparam int                   BCNT_W      = $clog2(BURSTS_PER_FRAME + 1);
   localparam logic [ADDR_W-1:0]    BURST_BYTES = ADDR_W'(BURST_LEN * DATA_BYTES);
   localparam logic [BCNT_W-1:0]    LAST_CNT    = BCNT_W'(BURSTS_PER_FRAME);
   localparam logic [CNT_W:0]       LEVEL_MIN   = (CNT_W + 1)'(BURST_LEN);
   localparam logic [BUF_IDX_W-1:0] BUF_LAST    = BUF_IDX_W'(BUF_NUM - 1);

   wr_state_e            state_q;
   logic [BUF_IDX_W-1:0] cur_buf_q, wbuf_q, start_buf_d, next_buf_d;
   logic [ADDR_W-1:0]    frame_base_q, burst_addr_q, waddr_q, start_base_d;
   logic [BCNT_W-1:0]    burst_cnt_q, burst_cnt_d;
   logic                 wbusy_q, wareq_q, wirq_q, active_q, pend_q;
   logic                 busy_fall_d, level_ok_d;

`ifdef UIVBUF_SW_SEL_EN
   assign start_buf_d = ({1'b0, axi_fdma_wbuf} >= (BUF_IDX_W + 1)'(BUF_NUM)) ? '0 : axi_fdma_wbuf;
   assign next_buf_d  = cur_buf_q;
`else
   logic unused_sw_sel;
   assign unused_sw_sel = ^axi_fdma_wbuf;
   assign start_buf_d   = cur_buf_q;
   assign next_buf_d    = (cur_buf_q == BUF_LAST) ? '0 : cur_buf_q + BUF_IDX_W'(1);
`endif

   // The only multiply is per frame; per-burst addresses are accumulated.
   assign start_base_d = ADDR_W'(BUF_BASE) + ADDR_W'(start_buf_d) * ADDR_W'(BUF_SIZE);
   assign burst_cnt_d  = burst_cnt_q + BCNT_W'(1);
   assign busy_fall_d  = wbusy_q & ~fdma_wbusy;
   assign level_ok_d   = {1'b0, fifo_rcnt} >= LEVEL_MIN;

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_q      <= ST_IDLE;
         cur_buf_q    <= '0;
         wbuf_q       <= '0;
         frame_base_q <= '0;
         burst_addr_q <= '0;
         waddr_q      <= '0;
         burst_cnt_q  <= '0;
         wbusy_q      <= 1'b0;
         wareq_q      <= 1'b0;
         wirq_q       <= 1'b0;
         active_q     <= 1'b0;
         pend_q       <= 1'b0;
      end else begin
         wbusy_q <= fdma_wbusy;
         case (state_q)
            ST_IDLE: begin
               if (frame_start || pend_q) begin
                  cur_buf_q    <= start_buf_d;
                  frame_base_q <= start_base_d;
                  burst_addr_q <= start_base_d;
                  burst_cnt_q  <= '0;
                  pend_q       <= 1'b0;
                  active_q     <= 1'b1;
                  state_q      <= ST_WAIT_DATA;
               end
            end
            ST_WAIT_DATA: begin
               if (frame_start) begin
                  burst_cnt_q  <= '0;
                  burst_addr_q <= frame_base_q;
               end else if (level_ok_d) begin
                  wareq_q <= 1'b1;
                  waddr_q <= burst_addr_q;
                  state_q <= ST_REQ;
               end
            end
            ST_REQ: begin
               // Once the engine has accepted, a new start must wait for the burst.
               if (fdma_wbusy) begin
                  wareq_q <= 1'b0;
                  pend_q  <= frame_start;
                  state_q <= ST_BUSY;
               end else if (frame_start) begin
                  wareq_q      <= 1'b0;
                  burst_cnt_q  <= '0;
                  burst_addr_q <= frame_base_q;
                  state_q      <= ST_WAIT_DATA;
               end
            end
            ST_BUSY: begin
               if (frame_start) pend_q <= 1'b1;
               if (busy_fall_d) begin
                  if (burst_cnt_d == LAST_CNT) begin
                     burst_cnt_q <= burst_cnt_d;
                     wirq_q      <= 1'b1;
                     wbuf_q      <= cur_buf_q;
                     active_q    <= 1'b0;
                     state_q     <= ST_DONE;
                  end else if (pend_q || frame_start) begin
                     burst_cnt_q  <= '0;
                     burst_addr_q <= frame_base_q;
                     pend_q       <= 1'b0;
                     state_q      <= ST_WAIT_DATA;
                  end else begin
                     burst_cnt_q  <= burst_cnt_d;
                     burst_addr_q <= burst_addr_q + BURST_BYTES;
                     state_q      <= ST_WAIT_DATA;
                  end
               end
            end
            ST_DONE: begin
               wirq_q    <= 1'b0;
               cur_buf_q <= next_buf_d;
               pend_q    <= pend_q | frame_start;
               state_q   <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign fdma_waddr = waddr_q;
   assign fdma_wareq = wareq_q;
   assign fdma_wsize = FDMA_SIZE_W'(BURST_LEN);
   assign fdma_wirq  = wirq_q;
   assign fdma_wbuf  = wbuf_q;
   assign wr_active  = active_q;

endmodule

`default_nettype wire

// File: tb/tb_uivbuf_wctrl.sv
// ============================================================================
// Module   : tb_uivbuf_wctrl
// Purpose  : Scoreboard bench for uivbuf_wctrl (burst addresses, IRQ buffers).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uivbuf_wctrl;

   localparam int          BL   = 16;
   localparam int          BPF  = 4;
   localparam int          NB   = 3;
   localparam int          DB   = 8;
   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam logic [31:0] SIZE = 32'h0080_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_start = 1'b0;
   logic [11:0] fifo_rcnt = 12'd0;
   logic        fdma_wbusy = 1'b0;
   logic [3:0]  axi_fdma_wbuf = 4'd0;
   logic [31:0] fdma_waddr;
   logic        fdma_wareq;
   logic [15:0] fdma_wsize;
   logic        fdma_wirq;
   logic [3:0]  fdma_wbuf;
   logic        wr_active;

   uivbuf_wctrl #(
      .DATA_BYTES(DB), .BURST_LEN(BL), .BURSTS_PER_FRAME(BPF), .BUF_NUM(NB)
   ) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .frame_start(frame_start),
      .fifo_rcnt(fifo_rcnt), .fdma_waddr(fdma_waddr), .fdma_wareq(fdma_wareq),
      .fdma_wsize(fdma_wsize), .fdma_wbusy(fdma_wbusy), .axi_fdma_wbuf(axi_fdma_wbuf),
      .fdma_wirq(fdma_wirq), .fdma_wbuf(fdma_wbuf), .wr_active(wr_active)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          bursts_served = 0;
   int          irq_seen = 0;
   int          mbuf = 0;
   logic [31:0] exp_addr_q[$];
   logic [3:0]  exp_buf_q[$];
   logic        prev_req = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] addr_of(input int b, input int i);
      return BASE + 32'(b) * SIZE + 32'(i * BL * DB);
   endfunction

   function automatic int frame_buf();
`ifdef UIVBUF_SW_SEL_EN
      return (int'(axi_fdma_wbuf) >= NB) ? 0 : int'(axi_fdma_wbuf);
`else
      return mbuf;
`endif
   endfunction

   task automatic expect_frame(input int b, input int nb, input bit done);
      for (int i = 0; i < nb; i++) exp_addr_q.push_back(addr_of(b, i));
      if (done) begin
         exp_buf_q.push_back(4'(b));
`ifndef UIVBUF_SW_SEL_EN
         mbuf = (b == NB - 1) ? 0 : b + 1;
`endif
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic wait_irqs(input int target, input string name);
      int t = 0;
      while (irq_seen < target && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check(name, 32'(irq_seen >= target), 32'd1);
   endtask

   task automatic wait_bursts(input int target, input string name);
      int t = 0;
      while (bursts_served < target && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check(name, 32'(bursts_served >= target), 32'd1);
   endtask

   // FDMA engine model: accepts a request and stays busy for four cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (fdma_wareq === 1'b1) begin
            fdma_wbusy = 1'b1;
            bursts_served++;
            repeat (4) @(negedge clk);
            fdma_wbusy = 1'b0;
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents a request or IRQ.
   always @(negedge clk) begin
      if (fdma_wareq === 1'b1 && !prev_req) begin
         if (exp_addr_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL waddr: unexpected request at %h, none expected", fdma_waddr);
         end else begin
            check("waddr", fdma_waddr, exp_addr_q.pop_front());
         end
      end
      if (fdma_wirq === 1'b1) begin
         irq_seen++;
         if (exp_buf_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wbuf: unexpected irq with buffer %0d, none expected", fdma_wbuf);
         end else begin
            check("wbuf", 32'(fdma_wbuf), 32'(exp_buf_q.pop_front()));
         end
      end
      prev_req <= fdma_wareq;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int b;
      int base;
      bit seen;
      fifo_rcnt = 12'd16;
      repeat (3) @(negedge clk);
      check("rst_wareq",  32'(fdma_wareq), 32'd0);
      check("rst_waddr",  fdma_waddr,      32'd0);
      check("rst_wirq",   32'(fdma_wirq),  32'd0);
      check("rst_wbuf",   32'(fdma_wbuf),  32'd0);
      check("rst_active", 32'(wr_active),  32'd0);
      check("wsize",      32'(fdma_wsize), 32'd16);
      rst_n = 1'b1;
      @(negedge clk);

      // Four back-to-back full frames, round robin over the buffers.
      for (int f = 0; f < 4; f++) begin
         b = frame_buf();
         expect_frame(b, BPF, 1'b1);
         pulse_start();
         if (f == 0) check("active_run", 32'(wr_active), 32'd1);
         wait_irqs(f + 1, "rr_irq_timeout");
         if (f == 0) check("active_done", 32'(wr_active), 32'd0);
         @(negedge clk);
      end

      // Starved FIFO: no request until the level reaches one burst.
      fifo_rcnt = 12'd15;
      b = frame_buf();
      expect_frame(b, BPF, 1'b1);
      pulse_start();
      seen = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (fdma_wareq) seen = 1'b1;
      end
      check("starve_no_req", 32'(seen), 32'd0);
      fifo_rcnt = 12'd16;
      @(negedge clk);
      check("starve_req_next", 32'(fdma_wareq), 32'd1);
      wait_irqs(5, "starve_irq_timeout");
      @(negedge clk);

      // Start during the last burst: frame completes, next frame via pending.
      b = frame_buf();
      expect_frame(b, BPF, 1'b1);
      b = frame_buf();
      expect_frame(b, BPF, 1'b1);
      base = bursts_served;
      pulse_start();
      wait_bursts(base + BPF, "last_busy_timeout");
      pulse_start();
      wait_irqs(7, "pend_irq_timeout");
      @(negedge clk);

      // Asynchronous reset in the middle of a burst.
      b = frame_buf();
      expect_frame(b, 1, 1'b0);
      base = bursts_served;
      pulse_start();
      wait_bursts(base + 1, "rst_busy_timeout");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_wareq",  32'(fdma_wareq), 32'd0);
      check("arst_waddr",  fdma_waddr,      32'd0);
      check("arst_wirq",   32'(fdma_wirq),  32'd0);
      check("arst_wbuf",   32'(fdma_wbuf),  32'd0);
      check("arst_active", 32'(wr_active),  32'd0);
      mbuf = 0;
      repeat (6) @(negedge clk);
      rst_n = 1'b1;
      check("arst_queue_empty", 32'(exp_addr_q.size()), 32'd0);

      // Abort while waiting for data after two bursts; restart in same buffer.
      b = frame_buf();
      expect_frame(b, 2, 1'b0);
      expect_frame(b, BPF, 1'b1);
      base = bursts_served;
      pulse_start();
      wait_bursts(base + 2, "abort_busy_timeout");
      fifo_rcnt = 12'd0;
      repeat (8) @(negedge clk);
      check("abort_active", 32'(wr_active), 32'd1);
      pulse_start();
      fifo_rcnt = 12'd16;
      wait_irqs(8, "abort_irq_timeout");

`ifdef UIVBUF_SW_SEL_EN
      @(negedge clk);
      axi_fdma_wbuf = 4'd2;
      expect_frame(2, BPF, 1'b1);
      pulse_start();
      wait_irqs(9, "sw2_irq_timeout");
      @(negedge clk);
      axi_fdma_wbuf = 4'd7;
      expect_frame(0, BPF, 1'b1);
      pulse_start();
      wait_irqs(10, "sw7_irq_timeout");
      repeat (20) @(negedge clk);
      check("irq_total", 32'(irq_seen), 32'd10);
`else
      repeat (20) @(negedge clk);
      check("irq_total", 32'(irq_seen), 32'd8);
`endif
      check("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
      check("irq_queue_empty",  32'(exp_buf_q.size()),  32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
